// File: rtl/sfp_pkg.sv
// Shared definitions for the softmax-style L1 normalisation row.
//
// Contents:
//   sum_w    - width of the unsigned absolute row sum, BW_PSUM + $clog2(COL).
//   ptr_w    - FIFO pointer width, one wrap bit above the address bits.
//   lane_abs - two's-complement magnitude of a sign-extended lane value.
//              The most negative lane maps to its positive magnitude because
//              the caller widens the lane before taking the magnitude.
package sfp_pkg;

  function automatic int sum_w(input int bw_psum, input int col);
    return bw_psum + $clog2(col);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [63:0] lane_abs(input logic signed [63:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/sfp_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
//
// Parameters:
//   BW    - entry width
//   DEPTH - number of entries (power of two, at least 2)
//
// Ports:
//   clk, reset - clock and synchronous active-high reset (pointers only)
//   wr, in     - write request and data; ignored while full
//   rd         - read request; ignored while empty
//   out        - head entry, combinational from the read pointer
//   full       - wrap bits differ, address bits equal
//   empty      - pointers identical
//   count      - entries held, 0..DEPTH
module sfp_sync_fifo
  import sfp_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [BW-1:0]              in,
  output logic [BW-1:0]              out,
  output logic                       full,
  output logic                       empty,
  output logic [ptr_w(DEPTH)-1:0]    count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [BW-1:0] mem_q [DEPTH];
  logic          wr_en;
  logic          rd_en;

  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;
  assign out   = mem_q[rptr_q[AW-1:0]];

  // Status is taken from registered pointers, so a write to a full FIFO is
  // refused even when a read happens in the same cycle.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= in;
  end

endmodule

// File: rtl/sfp_norm_row.sv
// Softmax-style L1 normalisation row for the accumulator output path.
//
// Each accepted row is buffered together with its absolute lane sum; the sum
// is also exported to a peer core. A divide request pops the oldest row and
// divides every lane by (local_sum >> DIV_SHIFT), optionally plus the peer's
// (sum_in >> DIV_SHIFT) in two-core mode.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   mode                    - 0 two-core divisor, 1 single-core divisor
//   acc, in_data, acc_ready - row push handshake
//   div, div_ready          - pop/divide handshake
//   sum_in, sum_in_valid,
//   sum_in_rd               - peer sum FIFO head and pop strobe
//   sum_out, sum_out_valid,
//   sum_out_rd              - local export sum FIFO head and peer pop
//   out_data, out_valid     - normalised row, one-cycle strobe, data held
//   count                   - rows buffered
//   ovf, div_zero           - sticky error flags
module sfp_norm_row
  import sfp_pkg::*;
#(
  parameter int  COL       = 8,
  parameter int  BW_PSUM   = 20,
  parameter int  DEPTH     = 16,
  parameter int  DIV_SHIFT = 7,
  localparam int SUM_W     = sum_w(BW_PSUM, COL)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       acc,
  input  logic [COL*BW_PSUM-1:0]     in_data,
  output logic                       acc_ready,
  input  logic                       div,
  output logic                       div_ready,
  input  logic [SUM_W-1:0]           sum_in,
  input  logic                       sum_in_valid,
  output logic                       sum_in_rd,
  output logic [SUM_W-1:0]           sum_out,
  output logic                       sum_out_valid,
  input  logic                       sum_out_rd,
  output logic [COL*BW_PSUM-1:0]     out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       div_zero
);

  localparam int RW = COL * BW_PSUM;
  localparam int FW = RW + SUM_W;
  // Quotient width: room for the sign-extended lane and the zero-extended
  // SUM_W+1 bit divisor.
  localparam int QW = SUM_W + 2;

  // Signed lane divide, truncating toward zero; a zero divisor yields 0.
  function automatic logic [BW_PSUM-1:0] div_lane(input logic signed [BW_PSUM-1:0] num,
                                                  input logic [SUM_W:0]            den);
    logic signed [QW-1:0] n;
    logic signed [QW-1:0] d;
    logic signed [QW-1:0] q;
    n = QW'(num);
    d = $signed({1'b0, den});
    if (den == '0) q = '0;
    else           q = n / d;
    return q[BW_PSUM-1:0];
  endfunction

  logic [SUM_W-1:0]           lane_mag [COL];
  logic [SUM_W-1:0]           acc_sum;
  logic                       acc_fire;
  logic                       div_fire;

  logic                       row_full;
  logic                       row_empty;
  logic [FW-1:0]              row_head;
  logic [RW-1:0]              head_row;
  logic [SUM_W-1:0]           head_sum;

  logic                       exp_full;
  logic                       exp_empty;
  logic                       exp_rd;
  logic [$clog2(DEPTH):0]     exp_count;

  logic [SUM_W-1:0]           local_term;
  logic [SUM_W-1:0]           peer_term;
  logic [SUM_W:0]             divisor;
  logic [RW-1:0]              quot;

  logic [RW-1:0]              out_data_q, out_data_d;
  logic                       out_valid_q;
  logic                       ovf_q, ovf_d;
  logic                       div_zero_q, div_zero_d;

  // ---------------- input stage: absolute row sum ----------------
  for (genvar i = 0; i < COL; i++) begin : g_abs
    logic signed [BW_PSUM-1:0] in_lane;
    assign in_lane     = in_data[i*BW_PSUM +: BW_PSUM];
    assign lane_mag[i] = SUM_W'(lane_abs(64'(in_lane)));
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < COL; i++) acc_sum = acc_sum + lane_mag[i];
  end

  // ---------------- handshakes ----------------
  assign acc_ready = ~row_full & ~exp_full;
  assign acc_fire  = acc & acc_ready;
  assign div_ready = ~row_empty & (mode | sum_in_valid);
  assign div_fire  = div & div_ready;
  assign sum_in_rd = div_fire & ~mode;

  // ---------------- buffering ----------------
  sfp_sync_fifo #(
    .BW    (FW),
    .DEPTH (DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (acc_fire),
    .rd    (div_fire),
    .in    ({acc_sum, in_data}),
    .out   (row_head),
    .full  (row_full),
    .empty (row_empty),
    .count (count)
  );

  assign head_row = row_head[RW-1:0];
  assign head_sum = row_head[FW-1:RW];

  assign exp_rd        = sum_out_rd & ~exp_empty;
  assign sum_out_valid = (exp_count != '0);

  sfp_sync_fifo #(
    .BW    (SUM_W),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (acc_fire),
    .rd    (exp_rd),
    .in    (acc_sum),
    .out   (sum_out),
    .full  (exp_full),
    .empty (exp_empty),
    .count (exp_count)
  );

  // ---------------- divide stage ----------------
  assign local_term = head_sum >> DIV_SHIFT;
  assign peer_term  = mode ? '0 : (sum_in >> DIV_SHIFT);
  assign divisor    = {1'b0, local_term} + {1'b0, peer_term};

  for (genvar i = 0; i < COL; i++) begin : g_div
    logic signed [BW_PSUM-1:0] head_lane;
    assign head_lane                 = head_row[i*BW_PSUM +: BW_PSUM];
    assign quot[i*BW_PSUM +: BW_PSUM] = div_lane(head_lane, divisor);
  end

  always_comb begin
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (acc & ~acc_ready);
    div_zero_d = div_zero_q | (div_fire & (divisor == '0));
    if (div_fire) out_data_d = quot;
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= div_fire;
      ovf_q       <= ovf_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_sfp_norm_row.sv
// Directed scoreboard bench for sfp_norm_row (COL=8, BW_PSUM=20, DEPTH=16,
// DIV_SHIFT=7). Expected rows are queued when a divide is issued; the monitor
// pops one on every out_valid.
module tb_sfp_norm_row;

  localparam int COL       = 8;
  localparam int BW        = 20;
  localparam int DEPTH     = 16;
  localparam int DIV_SHIFT = 7;
  localparam int SUM_W     = 23;
  localparam int RW        = COL * BW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mode = 1'b1;
  logic             acc = 1'b0;
  logic [RW-1:0]    in_data = '0;
  logic             acc_ready;
  logic             div = 1'b0;
  logic             div_ready;
  logic [SUM_W-1:0] sum_in = '0;
  logic             sum_in_valid = 1'b0;
  logic             sum_in_rd;
  logic [SUM_W-1:0] sum_out;
  logic             sum_out_valid;
  logic             sum_out_rd = 1'b0;
  logic [RW-1:0]    out_data;
  logic             out_valid;
  logic [4:0]       count;
  logic             ovf;
  logic             div_zero;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] sb [$];

  sfp_norm_row #(
    .COL       (COL),
    .BW_PSUM   (BW),
    .DEPTH     (DEPTH),
    .DIV_SHIFT (DIV_SHIFT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .acc           (acc),
    .in_data       (in_data),
    .acc_ready     (acc_ready),
    .div           (div),
    .div_ready     (div_ready),
    .sum_in        (sum_in),
    .sum_in_valid  (sum_in_valid),
    .sum_in_rd     (sum_in_rd),
    .sum_out       (sum_out),
    .sum_out_valid (sum_out_valid),
    .sum_out_rd    (sum_out_rd),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .count         (count),
    .ovf           (ovf),
    .div_zero      (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_alt(input int a, input int b);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = (i % 2 == 0) ? BW'(a) : BW'(b);
    return r;
  endfunction

  function automatic logic [RW-1:0] row_one(input int a);
    logic [RW-1:0] r;
    r = '0;
    r[BW-1:0] = BW'(a);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [RW-1:0] r);
    acc     = 1'b1;
    in_data = r;
    step();
    acc = 1'b0;
  endtask

  task automatic pop_export();
    sum_out_rd = 1'b1;
    step();
    sum_out_rd = 1'b0;
  endtask

  task automatic fire_div(input string name, input logic [RW-1:0] exp, input logic exp_rd);
    div = 1'b1;
    #1;
    check({name, "_div_ready"}, div_ready, 1'b1);
    check({name, "_sum_in_rd"}, sum_in_rd, exp_rd);
    sb.push_back(exp);
    step();
    div = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got out_valid=1 data %0h expected no output", out_data);
      end else begin
        check("out_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_sum_out_valid", sum_out_valid, 0);
    check("rst_sum_in_rd", sum_in_rd, 0);
    check("rst_acc_ready", acc_ready, 1);
    check("rst_div_ready", div_ready, 0);

    // Divide with nothing buffered: no output expected
    mode = 1'b1;
    div  = 1'b1;
    #1;
    check("empty_div_ready", div_ready, 0);
    step();
    div = 1'b0;
    step();

    // Single-core mode: 1024s, sum 8192, divisor 64 -> 16
    push(row_alt(1024, 1024));
    check("sc_count", count, 1);
    check("sc_div_ready", div_ready, 1);
    check("sc_sum_out_valid", sum_out_valid, 1);
    check("sc_sum_out", sum_out, 8192);
    pop_export();
    check("sc_export_empty", sum_out_valid, 0);
    fire_div("sc", row_alt(16, 16), 1'b0);
    check("sc_out_valid_lat", out_valid, 1);
    check("sc_count_after", count, 0);
    step();
    check("sc_out_strobe", out_valid, 0);
    check("sc_out_hold", out_data, row_alt(16, 16));

    // Signed lanes: -1024/+1024 -> -16/+16
    push(row_alt(-1024, 1024));
    check("sg_sum_out", sum_out, 8192);
    pop_export();
    fire_div("sg", row_alt(-16, 16), 1'b0);

    // Truncation toward zero: -3 / (0 + 256>>7 = 2) = -1
    mode = 1'b0;
    push(row_one(-3));
    check("tr_sum_out", sum_out, 3);
    pop_export();
    sum_in       = 23'd256;
    sum_in_valid = 1'b1;
    fire_div("tr", row_one(-1), 1'b1);
    sum_in_valid = 1'b0;

    // Two-core exchange: stalls without a peer sum, then divisor 128 -> 8
    push(row_alt(1024, 1024));
    pop_export();
    div = 1'b1;
    #1;
    check("tc_stall_div_ready", div_ready, 0);
    check("tc_stall_sum_in_rd", sum_in_rd, 0);
    step();
    div = 1'b0;
    check("tc_stall_count", count, 1);
    sum_in       = 23'd8192;
    sum_in_valid = 1'b1;
    fire_div("tc", row_alt(8, 8), 1'b1);
    sum_in_valid = 1'b0;
    mode         = 1'b1;
    check("tc_div_zero_clear", div_zero, 0);

    // Divide by zero: lanes 5, sum 40, divisor 0
    push(row_alt(5, 5));
    check("dz_sum_out", sum_out, 40);
    pop_export();
    fire_div("dz", row_alt(0, 0), 1'b0);
    check("dz_flag", div_zero, 1);
    step();
    step();
    check("dz_sticky", div_zero, 1);

    // Full / concurrency
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("full_rst_count", count, 0);
    check("full_rst_div_zero", div_zero, 0);
    for (int i = 0; i < DEPTH; i++) push(row_alt(1024, 1024));
    check("full_count", count, 16);
    check("full_acc_ready", acc_ready, 0);
    check("full_ovf_clear", ovf, 0);
    acc = 1'b1;
    #1;
    check("full_17_acc_ready", acc_ready, 0);
    step();
    acc = 1'b0;
    check("full_ovf", ovf, 1);
    check("full_17_count", count, 16);

    acc        = 1'b1;
    div        = 1'b1;
    sum_out_rd = 1'b1;
    sb.push_back(row_alt(16, 16));
    #1;
    check("cc1_div_ready", div_ready, 1);
    step();
    acc        = 1'b0;
    div        = 1'b0;
    sum_out_rd = 1'b0;
    check("cc1_count", count, 15);
    check("cc1_acc_ready", acc_ready, 1);

    acc        = 1'b1;
    div        = 1'b1;
    sum_out_rd = 1'b1;
    sb.push_back(row_alt(16, 16));
    step();
    acc        = 1'b0;
    div        = 1'b0;
    sum_out_rd = 1'b0;
    check("cc2_count", count, 15);
    check("cc2_ovf_sticky", ovf, 1);
    step();

    // Reset mid-stream
    reset = 1'b1;
    step();
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_acc_ready", acc_ready, 1);
    check("mid_rst_sum_out_valid", sum_out_valid, 0);
    reset = 1'b0;
    step();
    step();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfp_norm_row.md
# sfp_norm_row

Parametrised special-function (softmax-style L1 normalisation) row for the accumulator output path. It buffers COL signed partial sums per row and, in the same cycle, computes that row's absolute sum. On each divide request it divides every lane by a shifted divisor. The divisor is this core's sum alone, or this core's sum plus a peer core's sum, exchanged through a dedicated sum FIFO.

## Interface
- COL, 8, lanes per row
- BW_PSUM, 20, signed lane width
- DEPTH, 16, row FIFO depth; power of two
- DIV_SHIFT, 7, right shift applied to each sum before forming the divisor
- SUM_W (derived, not overridable), BW_PSUM+$clog2(COL), unsigned absolute-sum width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mode  in  1  0 = two-core divisor, 1 = single-core divisor; sampled at each div fire
- acc  in  1  push request for one row
- in_data  in  COL*BW_PSUM  row; lane i at [i*BW_PSUM +: BW_PSUM]
- acc_ready  out  1  row push allowed
- div  in  1  pop/divide request
- div_ready  out  1  pop allowed
- sum_in  in  SUM_W  peer core's absolute sum
- sum_in_valid  in  1  peer sum available
- sum_in_rd  out  1  pop strobe to the peer's sum FIFO
- sum_out  out  SUM_W  head of the local export sum FIFO
- sum_out_valid  out  1  export FIFO not empty
- sum_out_rd  in  1  peer pops the export FIFO
- out_data  out  COL*BW_PSUM  normalised row
- out_valid  out  1  out_data valid (one-cycle strobe)
- count  out  $clog2(DEPTH)+1  rows held in the row FIFO
- ovf  out  1  sticky: acc while not acc_ready
- div_zero  out  1  sticky: divisor was 0 on a div fire

## Operation
- Absolute sum: abs_i = two's-complement magnitude of lane i. The sum is the zero-extended SUM_W addition of all abs_i.
  - -2^(BW_PSUM-1) maps to 2^(BW_PSUM-1); no saturation.
- acc_fire = acc & acc_ready.
  - Writes {row, sum} into the row FIFO.
  - Writes sum into the export FIFO.
  - Both writes happen in the same cycle.
- acc_ready = !row_full & !exp_full. An acc while not ready is dropped and sets ovf.
- div_ready = !row_empty & (mode | sum_in_valid).
- div_fire = div & div_ready:
  - Pops the row FIFO.
  - sum_in_rd = div_fire & ~mode.
  - divisor = (sum_local >> DIV_SHIFT) + (mode ? 0 : sum_in >> DIV_SHIFT), unsigned, SUM_W+1 bits.
  - Each lane becomes signed dividend / zero-extended divisor, truncated toward zero. The result is the low BW_PSUM bits; it always fits because |quotient| ≤ |dividend|.
  - If divisor == 0, every lane outputs 0 and div_zero is set.
- A div while not ready is ignored: no pop, no out_valid.
- Export FIFO pops on sum_out_rd & sum_out_valid. A pop while empty is ignored.
- Simultaneous acc_fire and div_fire: both take effect and count is unchanged. acc_ready/div_ready come from registered state only, so a push to a full FIFO is never accepted even when a pop occurs in the same cycle.
- ovf and div_zero clear only on reset.

## Timing
- Reset values:
  - All FIFO pointers 0.
  - count 0, out_valid 0, out_data 0, ovf 0, div_zero 0.
  - sum_out_valid 0, sum_in_rd 0.
  - acc_ready 1, div_ready 0.
- A pushed row is visible on the cycle after acc_fire (div_ready rises, count increments).
- Divide latency is 1: out_data and out_valid are registered at the clk edge following the div_fire cycle. Back-to-back div fires give back-to-back out_valid.
- out_data holds its value when out_valid is 0.
- sum_in_rd is combinational and asserted in the div_fire cycle. sum_in is consumed in that cycle.
- sum_out is the FIFO head, combinational from the registered read pointer. It is valid the cycle after the push.
- Pointers are $clog2(DEPTH)+1 bits and wrap.
  - Full: MSBs differ, rest equal.
  - Empty: all bits equal.
- Reset mid-operation discards all buffered rows and sums, and clears out_valid on that edge.

## Structure
- Package sfp_pkg holds:
  - SUM_W as a function of BW_PSUM and COL.
  - A pointer-width helper.
  - An lane-absolute function.
- Sub-module sfp_sync_fifo (parameters BW, DEPTH; ports wr, rd, in, out, full, empty, count) is instantiated twice:
  - Row FIFO, width COL*BW_PSUM+SUM_W.
  - Export FIFO, width SUM_W.
- The lane divide array is a generate loop inside sfp_norm_row.

## Test plan
Parameters COL=8, BW_PSUM=20, DEPTH=16, DIV_SHIFT=7.
- Reset: all outputs follow the reset values above, including acc_ready=1 and div_ready=0. A div with nothing buffered produces no out_valid.
- Single-core mode: mode=1, push all lanes 1024. sum_out=8192, divisor=64, div → out_valid the next cycle with every lane 16.
- Signed lanes: mode=1, lanes alternating -1024/+1024. Sum=8192, lanes -16/+16. Also check lane 0 = -3, others 0 with a 1-row divisor forced: quotient truncates toward zero.
- Two-core exchange:
  - mode=0, row of 1024s, sum_in=8192, sum_in_valid=1: div → sum_in_rd pulse, divisor=128, lanes 8.
  - With sum_in_valid=0, div_ready stays 0.
- Divide by zero: mode=1, lanes all 5. Sum=40, divisor 0 → lanes 0, div_zero=1 and sticky.
- Full/concurrency:
  - 16 pushes: acc_ready=0, count=16. A 17th acc is dropped and sets ovf.
  - Then acc+div in the same cycle: only the pop occurs, count=15.
  - Then acc+div in the same cycle again: count stays 15.
  - Reset mid-stream: count returns to 0.
